// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scheduler
//  Purpose  : Hazard control for the 5-stage core. Tracks the destinations
//             held in EX and MEM in a shadow scoreboard, produces the execute
//             stage forward selects, detects load-use hazards (1-cycle stall
//             plus bubble), and runs a wrong-path squash sequence after a
//             taken branch.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             id_*                 - fields of the instruction leaving decode
//             branch_signal        - execute's registered taken-branch flag
//             forward_sig1/2       - registered forward selects for EX
//             flush                - kill the instruction in EX
//             bubble_ex            - ID/EX register loads a NOP
//             stall_if, stall_id   - hold PC and decode register
//             flush_if             - kill the instruction in fetch/decode
//             redirect_busy        - squash sequence in progress
//             stall_count,
//             flush_count          - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scheduler #(
  parameter int REDIRECT_CYCLES = 2,   // legal range 1..7
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_write_reg,
  input  logic [4:0]       id_dst_addr,
  input  logic             id_is_load,
  input  logic             branch_signal,
  output logic [1:0]       forward_sig1,
  output logic [1:0]       forward_sig2,
  output logic             flush,
  output logic             bubble_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] C_FWD_NORMAL    = 2'b00;
  localparam logic [1:0] C_FWD_WRITEMEM  = 2'b01;
  localparam logic [1:0] C_FWD_WRITEBACK = 2'b10;
  localparam logic [2:0] C_RCNT_INIT     = 3'(REDIRECT_CYCLES - 1);

  typedef struct packed {
    logic       valid;
    logic       write_reg;
    logic [4:0] dst;
    logic       is_load;
  } slot_t;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_rcnt, w_rcnt_next;
  slot_t            r_ex_slot, r_mem_slot, w_ex_slot_next;
  logic [1:0]       r_fwd1, r_fwd2, w_fwd1_next, w_fwd2_next;
  logic [CNT_W-1:0] r_stall_count, r_flush_count;

  logic w_branch, w_redirect, w_load_use, w_stall, w_bubble;
  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  function automatic logic slot_match(input slot_t s, input logic used,
                                      input logic [4:0] src);
    return used && s.valid && s.write_reg && (s.dst == src) && (src != 5'd0);
  endfunction

  assign w_ex_m1  = slot_match(r_ex_slot,  id_uses_rs1, id_rs1_addr);
  assign w_ex_m2  = slot_match(r_ex_slot,  id_uses_rs2, id_rs2_addr);
  assign w_mem_m1 = slot_match(r_mem_slot, id_uses_rs1, id_rs1_addr);
  assign w_mem_m2 = slot_match(r_mem_slot, id_uses_rs2, id_rs2_addr);

  // Branch is only honoured in RUN: in REDIRECT it comes from a squashed op.
  assign w_redirect = (r_state == ST_REDIRECT);
  assign w_branch   = (r_state == ST_RUN) && branch_signal;
  assign w_load_use = id_valid && r_ex_slot.is_load && (w_ex_m1 || w_ex_m2);
  // Stall only in RUN and only when no branch is taken: the branch squashes
  // the consumer anyway, so stalling would just waste a cycle.
  assign w_stall    = w_load_use && (r_state == ST_RUN) && !branch_signal;
  assign w_bubble   = w_branch || w_redirect || w_stall;

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = r_rcnt;
    case (r_state)
      ST_RUN: begin
        if (branch_signal) begin
          w_state_next = ST_REDIRECT;
          w_rcnt_next  = C_RCNT_INIT;
        end
      end
      ST_REDIRECT: begin
        if (r_rcnt == 3'd0) begin
          w_state_next = ST_RUN;
        end else begin
          w_rcnt_next = r_rcnt - 3'd1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_rcnt_next  = 3'd0;
      end
    endcase
  end

  // Next EX slot and forward selects for the instruction entering EX. The
  // current EX producer will be in MEM when the consumer executes, hence
  // WRITEMEM; it is the newer producer so it has priority.
  always_comb begin
    w_ex_slot_next = '0;
    w_fwd1_next    = C_FWD_NORMAL;
    w_fwd2_next    = C_FWD_NORMAL;
    if (id_valid && !w_bubble) begin
      w_ex_slot_next.valid     = 1'b1;
      w_ex_slot_next.write_reg = id_write_reg;
      w_ex_slot_next.dst       = id_dst_addr;
      w_ex_slot_next.is_load   = id_is_load;
      if (w_ex_m1)       w_fwd1_next = C_FWD_WRITEMEM;
      else if (w_mem_m1) w_fwd1_next = C_FWD_WRITEBACK;
      if (w_ex_m2)       w_fwd2_next = C_FWD_WRITEMEM;
      else if (w_mem_m2) w_fwd2_next = C_FWD_WRITEBACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_rcnt        <= 3'd0;
      r_ex_slot     <= '0;
      r_mem_slot    <= '0;
      r_fwd1        <= C_FWD_NORMAL;
      r_fwd2        <= C_FWD_NORMAL;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rcnt     <= w_rcnt_next;
      r_mem_slot <= r_ex_slot;
      r_ex_slot  <= w_ex_slot_next;
      r_fwd1     <= w_fwd1_next;
      r_fwd2     <= w_fwd2_next;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_branch && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign forward_sig1  = r_fwd1;
  assign forward_sig2  = r_fwd2;
  assign flush         = w_branch;
  assign bubble_ex     = w_bubble;
  assign stall_if      = w_stall;
  assign stall_id      = w_stall;
  assign flush_if      = w_branch || w_redirect;
  assign redirect_busy = w_redirect;
  assign stall_count   = r_stall_count;
  assign flush_count   = r_flush_count;

endmodule
`default_nettype wire

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard scheduler for the 5-stage core: sequences the execute stage by generating its `forward_sig1`/`forward_sig2` selects, its `flush`, and the stall and bubble controls for fetch, decode and the decode-to-execute register. It keeps a shadow scoreboard of the destinations held in the EX and MEM stages and detects load-use hazards. On a taken branch it runs a redirect sequence of programmable length. It sits beside the decode stage and is driven by decode's outgoing instruction fields and execute's registered `branch_signal`.

## Interface
- `REDIRECT_CYCLES`, default 2: cycles of wrong-path squash after a taken branch, legal range 1..7.
- `CNT_W`, default 16: width of the saturating event counters.

- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode holds a valid instruction that enters EX on the next edge.
- `id_rs1_addr`, `id_rs2_addr`  in  5 each  source registers of that instruction.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  source actually read.
- `id_write_reg`  in  1  instruction writes a register.
- `id_dst_addr`  in  5  destination register.
- `id_is_load`  in  1  instruction is a load (`info_load` is not NOTLOAD).
- `branch_signal`  in  1  execute's registered taken-branch flag.
- `forward_sig1`, `forward_sig2`  out  2 each  forward selects for execute: NORMAL=2'b00, WRITEMEM=2'b01, WRITEBACK=2'b10.
- `flush`  out  1  to execute; kills the instruction currently in EX.
- `bubble_ex`  out  1  decode-to-execute register loads a NOP.
- `stall_if`, `stall_id`  out  1 each  hold the PC and the decode register.
- `flush_if`  out  1  kill the instruction in fetch/decode.
- `redirect_busy`  out  1  FSM is in REDIRECT.
- `stall_count`, `flush_count`  out  CNT_W each  saturating event counters.

## Operation
- Shadow slots `ex_slot` and `mem_slot` each hold {valid, write_reg, dst, is_load}.
  - Every edge: `mem_slot <= ex_slot`.
  - `ex_slot <=` the ID fields, or an invalid slot when `bubble_ex` is high or `id_valid` is low.
- A slot matches a source when: the source is used, the slot is valid, `write_reg` is set, `dst == src`, and `src != 0`.
- Forward select, registered at the edge on which the instruction enters EX, so it is valid for that instruction's whole EX cycle:
  - `ex_slot` match gives WRITEMEM.
  - Otherwise a `mem_slot` match gives WRITEBACK.
  - Otherwise NORMAL.
  - The newer producer, `ex_slot`, always wins.
- Load-use hazard, combinational: `ex_slot` is a load and it matches rs1 or rs2 of a valid ID instruction.
  - Response: `stall_if`, `stall_id` and `bubble_ex` all high for that cycle; `stall_count` increments.
  - On the next cycle the load sits in `mem_slot`, so the consumer receives WRITEBACK.
- FSM states: RUN and REDIRECT, plus a 3-bit counter `rcnt`.
  - RUN, when `branch_signal` is high: for that cycle `flush`, `bubble_ex` and `flush_if` are high. Next state is REDIRECT with `rcnt = REDIRECT_CYCLES-1`. `flush_count` increments.
  - REDIRECT: `bubble_ex` and `flush_if` are high, and load-use stalls are suppressed (the stall outputs stay 0). `rcnt` decrements; when `rcnt == 0` the next state is RUN.
  - `branch_signal` in REDIRECT is ignored, since it can only come from a squashed instruction.
- Simultaneous taken branch and load-use hazard: the branch wins. No stall is asserted and `stall_count` does not increment.
- Counters saturate at all-ones.

## Timing
- Reset values: state RUN, `rcnt` 0, both slots invalid, `forward_sig1`/`forward_sig2` NORMAL, both counters 0.
- Combinational outputs are also 0 while in reset, because the slots are invalid and the state is RUN: `flush`, `bubble_ex`, `stall_if`, `stall_id`, `flush_if`, `redirect_busy`.
- Reset asserted mid-REDIRECT returns everything to the reset values immediately.
- Latencies:
  - Hazard detection to stall: 0 cycles.
  - `branch_signal` to `flush`: 0 cycles.
  - REDIRECT lasts exactly REDIRECT_CYCLES cycles after the branch cycle.
- A load-use stall lasts exactly 1 cycle.
- Back-to-back loads each stall independently.
- A bubble never matches any source, so bubbles never cause forwarding.

## Test plan
- Dependent ALU pair: `add x5` followed by `sub x6,x5,x1` → the sub sees `forward_sig1=01` during EX, with no stall.
- Distance-2 dependency: `add x5`, an unrelated op, then `or x7,x2,x5` → `forward_sig2=10`. If both EX and MEM hold x5, the result is 01.
- Load-use: `lw x3` followed by `add x4,x3,x3` → 1 cycle with stall_if, stall_id and bubble_ex high; then both forward selects are 10; `stall_count` is 1.
- Writes to x0: a producer with `x0` destination followed by a consumer of x0 → forward selects stay 00.
- Taken branch with REDIRECT_CYCLES=2 → flush for 1 cycle, bubble_ex/flush_if for 3 cycles, redirect_busy for 2 cycles; `flush_count` is 1. A load-use pattern injected in that window produces no stall.
- Reset pulled low in the second REDIRECT cycle → all outputs return to their reset values asynchronously; normal forwarding resumes on the first edge after release.
